// File: rtl/i_fetch_if.sv
// i_fetch_if: instruction-memory read channel between the fetch stage and
// the instruction memory. The fetch stage holds IMemRd/IMemAddr as a level
// request; the memory answers with IMemDone plus IMemData in the cycle the
// word is valid.
interface i_fetch_if;
  logic        IMemRd;
  logic [15:0] IMemAddr;
  logic [15:0] IMemData;
  logic        IMemDone;

  modport master (
    output IMemRd,
    output IMemAddr,
    input  IMemData,
    input  IMemDone
  );

  modport slave (
    input  IMemRd,
    input  IMemAddr,
    output IMemData,
    output IMemDone
  );
endinterface

// File: rtl/i_fetch.sv
// i_fetch: instruction fetch stage with a one-entry skid buffer and an F/D
// pipeline register. It handles decode stalls, global freezes, and redirects
// that land while a memory request is still in flight.
// Optional feature macro: FETCH_HALT_FREEZE_EN. When it is defined, a valid
// HALT opcode (5'b00000) entering F/D parks the stage until a redirect or a
// reset.
module i_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic        Stall_D,
  input  logic        DataMemStall,
  i_fetch_if.master   imem,
  output logic [15:0] Inst_F,
  output logic [15:0] PCInc_F,
  output logic        Inst_F_Valid,
  output logic        err
);

  localparam logic [15:0] NOP = 16'h0800;

`ifdef FETCH_HALT_FREEZE_EN
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
`endif

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] fetch_addr_reg, fetch_addr_next;
  logic [15:0] buf_inst_reg, buf_inst_next;
  logic [15:0] buf_pc_inc_reg, buf_pc_inc_next;
  logic [15:0] inst_reg, inst_next;
  logic [15:0] pc_inc_reg, pc_inc_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;

  logic        accept_redirect;
  logic [15:0] redirect_target;
  logic [15:0] seq_addr;

  // A redirect is only taken when the pipeline is not globally frozen.
  assign accept_redirect = Redirect & ~DataMemStall;
  assign redirect_target = {RedirectPC[15:1], 1'b0};
  // 16-bit wrap is intended: 16'hFFFE advances to 16'h0000.
  assign seq_addr        = fetch_addr_reg + 16'd2;

  // Request is level-held in FETCH and DRAIN, and it is always suppressed
  // while reset is asserted.
  assign imem.IMemRd   = rst & ((state_reg == FETCH) | (state_reg == DRAIN));
  assign imem.IMemAddr = fetch_addr_reg;

  assign Inst_F       = inst_reg;
  assign PCInc_F      = pc_inc_reg;
  assign Inst_F_Valid = valid_reg;
  assign err          = err_reg;

  // Next-state logic for the fetch FSM, the PC/buffer and the F/D register.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    fetch_addr_next = fetch_addr_reg;
    buf_inst_next   = buf_inst_reg;
    buf_pc_inc_next = buf_pc_inc_reg;
    inst_next       = inst_reg;
    pc_inc_next     = pc_inc_reg;
    valid_next      = valid_reg;
    err_next        = 1'b0;

    if (accept_redirect) begin
      // A redirect flushes F/D and the buffer, and it beats Stall_D and
      // IMemDone.
      err_next        = RedirectPC[0];
      pc_next         = redirect_target;
      inst_next       = NOP;
      valid_next      = 1'b0;
      buf_inst_next   = 16'h0000;
      buf_pc_inc_next = 16'h0000;
      case (state_reg)
        FETCH, DRAIN: begin
          if (imem.IMemDone) begin
            // The in-flight word completes now and is simply dropped.
            fetch_addr_next = redirect_target;
            state_next      = FETCH;
          end else begin
            // Keep asking for the old address until the memory finishes it.
            state_next = DRAIN;
          end
        end
        default: begin
          fetch_addr_next = redirect_target;
          state_next      = FETCH;
        end
      endcase
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem.IMemDone) begin
            pc_next         = seq_addr;
            fetch_addr_next = seq_addr;
            if (Stall_D | DataMemStall) begin
              // Decode cannot take the word yet, so park it in the buffer.
              buf_inst_next   = imem.IMemData;
              buf_pc_inc_next = seq_addr;
              state_next      = HOLD;
            end else begin
              inst_next   = imem.IMemData;
              pc_inc_next = seq_addr;
              valid_next  = 1'b1;
`ifdef FETCH_HALT_FREEZE_EN
              if (imem.IMemData[15:11] == 5'b00000) state_next = HALT;
`endif
            end
          end
        end
        HOLD: begin
          if (!Stall_D && !DataMemStall) begin
            inst_next       = buf_inst_reg;
            pc_inc_next     = buf_pc_inc_reg;
            valid_next      = 1'b1;
            buf_inst_next   = 16'h0000;
            buf_pc_inc_next = 16'h0000;
            state_next      = FETCH;
`ifdef FETCH_HALT_FREEZE_EN
            if (buf_inst_reg[15:11] == 5'b00000) state_next = HALT;
`endif
          end
        end
        DRAIN: begin
          // The stale word is thrown away, and fetching resumes at the
          // redirect PC.
          if (imem.IMemDone) begin
            fetch_addr_next = pc_reg;
            state_next      = FETCH;
          end
        end
        default: begin
          // HALT holds everything until a redirect or a reset.
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= FETCH;
      pc_reg         <= 16'h0000;
      fetch_addr_reg <= 16'h0000;
      buf_inst_reg   <= 16'h0000;
      buf_pc_inc_reg <= 16'h0000;
      inst_reg       <= NOP;
      pc_inc_reg     <= 16'h0000;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      fetch_addr_reg <= fetch_addr_next;
      buf_inst_reg   <= buf_inst_next;
      buf_pc_inc_reg <= buf_pc_inc_next;
      inst_reg       <= inst_next;
      pc_inc_reg     <= pc_inc_next;
      valid_reg      <= valid_next;
      err_reg        <= err_next;
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: directed scenarios followed by random stimulus for i_fetch.
// A variable-latency memory responder feeds the DUT, and a flag-based
// behavioural model predicts every output.
// Honours FETCH_HALT_FREEZE_EN in the same way as the design.
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectPC = 16'h0000;
  logic        Stall_D = 1'b0;
  logic        DataMemStall = 1'b0;
  logic [15:0] Inst_F;
  logic [15:0] PCInc_F;
  logic        Inst_F_Valid;
  logic        err;

  int compared = 0;
  int mismatched = 0;

  i_fetch_if imem ();

  i_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .Stall_D      (Stall_D),
    .DataMemStall (DataMemStall),
    .imem         (imem),
    .Inst_F       (Inst_F),
    .PCInc_F      (PCInc_F),
    .Inst_F_Valid (Inst_F_Valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Memory environment
  int   cnt = 0;
  int   lat = 1;
  logic rand_lat = 1'b0;
  logic zero_at_8 = 1'b0;

  // Reference model: the request address, a pending-stale flag, the buffer,
  // and the F/D contents.
  logic [15:0] m_pc, m_req_addr, m_buf_inst, m_buf_inc, m_fd_inst, m_fd_inc;
  logic        m_stale, m_buf_valid, m_fd_valid, m_halted, m_err;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (zero_at_8 && a == 16'h0008) return 16'h0000;
    return 16'h4000 + a;
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [15:0] inst, input logic [15:0] inc);
    m_fd_inst  = inst;
    m_fd_inc   = inc;
    m_fd_valid = 1'b1;
`ifdef FETCH_HALT_FREEZE_EN
    if (inst[15:11] == 5'b00000) m_halted = 1'b1;
`endif
  endtask

  // One clock cycle. The task is entered just after a negedge, with the
  // inputs already driven.
  task automatic step();
    logic        exp_rd, d, rd_now, acc;
    logic [15:0] exp_addr, dat, tgt, nxt;
    #1;
    if (rand_lat && cnt == 0) lat = $urandom_range(1, 3);
    exp_rd   = rst && !m_buf_valid && !m_halted;
    exp_addr = m_stale ? m_req_addr : m_pc;
    check1("IMemRd", imem.IMemRd, exp_rd);
    if (exp_rd) check16("IMemAddr", imem.IMemAddr, exp_addr);
    rd_now = imem.IMemRd;
    if (!rst) d = 1'($urandom_range(0, 1));   // junk Done during reset
    else      d = rd_now && (cnt >= lat - 1);
    dat = (d && rst) ? mem_word(imem.IMemAddr) : 16'($urandom);
    imem.IMemDone = d;
    imem.IMemData = dat;
    @(posedge clk);
    if (!rst) begin
      m_pc = 16'h0000; m_req_addr = 16'h0000; m_stale = 1'b0;
      m_buf_valid = 1'b0; m_buf_inst = 16'h0000; m_buf_inc = 16'h0000;
      m_fd_inst = 16'h0800; m_fd_inc = 16'h0000; m_fd_valid = 1'b0;
      m_halted = 1'b0; m_err = 1'b0;
      cnt = 0;
    end else begin
      acc   = Redirect && !DataMemStall;
      tgt   = RedirectPC & 16'hFFFE;
      m_err = acc && RedirectPC[0];
      if (acc) begin
        if (!m_halted && !m_buf_valid && !m_stale && !d) begin
          m_stale    = 1'b1;
          m_req_addr = m_pc;
        end else if (m_stale && d) begin
          m_stale = 1'b0;
        end
        m_pc = tgt; m_buf_valid = 1'b0; m_halted = 1'b0;
        m_fd_inst = 16'h0800; m_fd_valid = 1'b0;
      end else if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_stale) begin
        if (d) m_stale = 1'b0;
      end else if (m_buf_valid) begin
        if (!Stall_D && !DataMemStall) begin
          model_load(m_buf_inst, m_buf_inc);
          m_buf_valid = 1'b0;
        end
      end else if (d) begin
        nxt = m_pc + 16'd2;
        if (Stall_D || DataMemStall) begin
          m_buf_inst = dat; m_buf_inc = nxt; m_buf_valid = 1'b1;
        end else begin
          model_load(dat, nxt);
        end
        m_pc = nxt;
      end
      if (d || !rd_now) cnt = 0;
      else              cnt++;
    end
    #1;
    check16("Inst_F", Inst_F, m_fd_inst);
    check16("PCInc_F", PCInc_F, m_fd_inc);
    check1("Inst_F_Valid", Inst_F_Valid, m_fd_valid);
    check1("err", err, m_err);
    $display("cyc rst=%b rd=%b done=%b redir=%b stall=%b dms=%b inst=%h inc=%h v=%b err=%b",
             rst, rd_now, d, Redirect, Stall_D, DataMemStall, Inst_F, PCInc_F, Inst_F_Valid, err);
    @(negedge clk);
  endtask

  task automatic reset_seq();
    rst = 1'b0; Redirect = 1'b0; Stall_D = 1'b0; DataMemStall = 1'b0;
    step();
    step();
    check16("rst_inst", Inst_F, 16'h0800);
    check16("rst_inc", PCInc_F, 16'h0000);
    check1("rst_valid", Inst_F_Valid, 1'b0);
    check1("rst_rd", imem.IMemRd, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    imem.IMemDone = 1'b0;
    imem.IMemData = 16'h0000;
    @(negedge clk);

    // Single-cycle memory: back-to-back fetches after reset.
    lat = 1;
    reset_seq();
    for (int k = 1; k <= 5; k++) begin
      step();
      check16("seq_inc", PCInc_F, 16'(2 * k));
      check16("seq_inst", Inst_F, 16'(16'h4000 + 2 * (k - 1)));
      check1("seq_valid", Inst_F_Valid, 1'b1);
    end

    // Decode stall while the word at address 4 arrives.
    reset_seq();
    step(); step();
    Stall_D = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check16("stall_hold_inc", PCInc_F, 16'h0004);
    end
    Stall_D = 1'b0;
    step();
    check16("stall_rel_inc", PCInc_F, 16'h0006);
    check16("stall_rel_inst", Inst_F, 16'h4004);
    step();
    check16("stall_next_inc", PCInc_F, 16'h0008);

    // Latency 3 with an odd redirect while the request is in flight.
    reset_seq();
    lat = 3;
    step();
    Redirect = 1'b1; RedirectPC = 16'h0101;
    step();
    check1("drain_err", err, 1'b1);
    check1("drain_valid", Inst_F_Valid, 1'b0);
    Redirect = 1'b0;
    step();
    check1("drain_err_clr", err, 1'b0);
    check16("drain_newaddr", imem.IMemAddr, 16'h0100);
    step(); step();
    check1("drain_wait_valid", Inst_F_Valid, 1'b0);
    step();
    check1("drain_done_valid", Inst_F_Valid, 1'b1);
    check16("drain_done_inc", PCInc_F, 16'h0102);

    // PC wrap from 16'hFFFE.
    lat = 1;
    Redirect = 1'b1; RedirectPC = 16'hFFFE;
    step();
    Redirect = 1'b0;
    step();
    check16("wrap_inc", PCInc_F, 16'h0000);
    check1("wrap_err", err, 1'b0);
    check16("wrap_addr", imem.IMemAddr, 16'h0000);

    // HALT opcode at address 8.
    zero_at_8 = 1'b1;
    Redirect = 1'b1; RedirectPC = 16'h0008;
    step();
    Redirect = 1'b0;
    step();
    check16("halt_inst", Inst_F, 16'h0000);
    check16("halt_inc", PCInc_F, 16'h000A);
`ifdef FETCH_HALT_FREEZE_EN
    check1("halt_rd", imem.IMemRd, 1'b0);
    step();
    check1("halt_rd_held", imem.IMemRd, 1'b0);
    check16("halt_inc_held", PCInc_F, 16'h000A);
    Redirect = 1'b1; RedirectPC = 16'h0020;
    step();
    Redirect = 1'b0;
    step();
    check16("halt_resume_inc", PCInc_F, 16'h0022);
`else
    check1("nohalt_rd", imem.IMemRd, 1'b1);
    check16("nohalt_addr", imem.IMemAddr, 16'h000A);
    step();
    check16("nohalt_inc", PCInc_F, 16'h000C);
`endif

    // Random mix of redirects, stalls, freezes, resets and latencies.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) >= 2);
      Redirect     = ($urandom_range(0, 99) < 10);
      RedirectPC   = 16'($urandom_range(0, 63));
      Stall_D      = ($urandom_range(0, 99) < 30);
      DataMemStall = ($urandom_range(0, 99) < 15);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
